// File: rtl/relm_custom_div.sv
// relm_custom_div: iterative integer divide/modulo unit for the ReLM custom-op slot.
// Runs a restoring shift-subtract divider that retires BPC quotient bits per cycle.
// It holds the core with retry_out until the result is ready.
// The shared multiplier is not used.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   op_in          custom opcode; the four DIV/MOD opcodes start an operation
//   a_in, x_in     dividend, divisor (latched only in IDLE)
//   cb_in, xb_in, opb_in, mul_ax_in   unused
//   mul_a_out, mul_x_out              tied to 0
//   a_out          primary result: quotient (DIV*) or remainder (MOD*)
//   cb_out         {WC zeros, secondary result}: remainder (DIV*) or quotient (MOD*)
//   retry_out      1 = core must re-present the same op/operands next cycle
module relm_custom_div #(
    parameter int unsigned WD  = 32,
    parameter int unsigned WOP = 5,
    parameter int unsigned WC  = 0,
    parameter int unsigned BPC = 1,
    parameter logic [WOP-1:0] OP_DIVU = WOP'(5'h1C),
    parameter logic [WOP-1:0] OP_DIVS = WOP'(5'h1D),
    parameter logic [WOP-1:0] OP_MODU = WOP'(5'h1E),
    parameter logic [WOP-1:0] OP_MODS = WOP'(5'h1F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WOP-1:0]    op_in,
    input  logic [WD-1:0]     a_in,
    input  logic [WC+WD-1:0]  cb_in,
    input  logic [WD-1:0]     x_in,
    input  logic [WD-1:0]     xb_in,
    input  logic              opb_in,
    input  logic [2*WD-1:0]   mul_ax_in,
    output logic [WD-1:0]     mul_a_out,
    output logic [WD-1:0]     mul_x_out,
    output logic [WD-1:0]     a_out,
    output logic [WC+WD-1:0]  cb_out,
    output logic              retry_out
);

    localparam int unsigned N   = WD / BPC;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned WCB = WC + WD;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [WD-1:0]   quo, quo_next;       // dividend bits shifting out, quotient bits shifting in
    logic [WD-1:0]   rem, rem_next;
    logic [WD-1:0]   dvs, dvs_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            is_mod, is_mod_next;
    logic            neg_q, neg_q_next;
    logic            neg_r, neg_r_next;
    logic [WD-1:0]   a_next;
    logic [WCB-1:0]  cb_next;

    logic            div_op, op_signed, op_mod;
    logic [WD-1:0]   a_abs, x_abs;
    logic [WD-1:0]   step_q, step_r, fix_q, fix_r;
    logic [WD:0]     trial;

    // Opcode decode
    assign div_op    = (op_in == OP_DIVU) || (op_in == OP_DIVS) ||
                       (op_in == OP_MODU) || (op_in == OP_MODS);
    assign op_signed = (op_in == OP_DIVS) || (op_in == OP_MODS);
    assign op_mod    = (op_in == OP_MODU) || (op_in == OP_MODS);

    assign a_abs = (op_signed && a_in[WD-1]) ? (WD'(0) - a_in) : a_in;
    assign x_abs = (op_signed && x_in[WD-1]) ? (WD'(0) - x_in) : x_in;

    // Stall is combinational so the core sees it in the same cycle as the op
    assign retry_out = !rst && div_op && (state != DONE);

    assign mul_a_out = '0;
    assign mul_x_out = '0;

    logic unused_inputs;
    assign unused_inputs = ^{cb_in, xb_in, opb_in, mul_ax_in};

    // BPC restoring steps per cycle, MSB first, plus sign fixup of the would-be final result
    always_comb begin
        step_q = quo;
        step_r = rem;
        trial  = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            trial  = {step_r, step_q[WD-1]};
            step_q = {step_q[WD-2:0], 1'b0};
            if (trial >= {1'b0, dvs}) begin
                trial     = trial - {1'b0, dvs};
                step_q[0] = 1'b1;
            end
            step_r = trial[WD-1:0];
        end
        fix_q = neg_q ? (WD'(0) - step_q) : step_q;
        fix_r = neg_r ? (WD'(0) - step_r) : step_r;
    end

    // Next-state and datapath next values
    always_comb begin
        state_next  = state;
        quo_next    = quo;
        rem_next    = rem;
        dvs_next    = dvs;
        cnt_next    = cnt;
        is_mod_next = is_mod;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;
        a_next      = a_out;
        cb_next     = cb_out;

        unique case (state)
            IDLE: begin
                if (div_op) begin
                    quo_next    = a_abs;
                    rem_next    = '0;
                    dvs_next    = x_abs;
                    cnt_next    = CW'(N);
                    is_mod_next = op_mod;
                    neg_q_next  = op_signed && (a_in[WD-1] ^ x_in[WD-1]);
                    neg_r_next  = op_signed && a_in[WD-1];
                    if (x_in == '0) begin
                        // Divide by zero: quotient all ones, remainder is the raw dividend
                        a_next     = op_mod ? a_in : {WD{1'b1}};
                        cb_next    = WCB'(op_mod ? {WD{1'b1}} : a_in);
                        state_next = DONE;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!div_op) begin
                    // Core withdrew the op: drop the partial result
                    state_next = IDLE;
                end else begin
                    quo_next = step_q;
                    rem_next = step_r;
                    cnt_next = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        a_next     = is_mod ? fix_r : fix_q;
                        cb_next    = WCB'(is_mod ? fix_q : fix_r);
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            is_mod <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_out  <= '0;
            cb_out <= '0;
        end else begin
            state  <= state_next;
            quo    <= quo_next;
            rem    <= rem_next;
            dvs    <= dvs_next;
            cnt    <= cnt_next;
            is_mod <= is_mod_next;
            neg_q  <= neg_q_next;
            neg_r  <= neg_r_next;
            a_out  <= a_next;
            cb_out <= cb_next;
        end
    end

endmodule
